// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
// Pattern-based read/write checker for the FIFO-style user ports of sdram_top.
// Each pass writes TEST_LEN words, idles for GAP_CYCLES so the write FIFO can
// flush to SDRAM, reads the words back and compares them against the regenerated
// pattern. Odd passes invert the data so that stale contents are detected.
//
// Ports:
//   clk_50m, rst_n        clock (rising edge) and asynchronous active-low reset
//   sdram_init_done       controller ready; dropping it returns the tester to IDLE
//   mode[1:0]             0 INC, 1 WALK1, 2 LFSR, 3 NOT-INC, sampled at pass start
//   stop_on_err           end the run at the first mismatch
//   wr_ready, rd_ready    FIFO handshakes gating the strobes
//   wr_en, wr_data        write strobe and data
//   rd_en, rd_data        read strobe and data (valid RD_LATENCY cycles after rd_en)
//   port_load             LOAD_CYCLES-wide reload pulse at the start of each pass
//   error_flag, err_cnt   sticky mismatch flag and saturating mismatch count
//   pass_cnt              completed passes (wraps)
//   busy                  high outside IDLE and STOP
//
// Optional feature macro SDRAM_TEST_ERR_LOG_EN adds first_err_addr, first_exp and
// first_act, which capture the first mismatch after reset.
module sdram_pattern_tester #(
  parameter int          DW          = 16,
  parameter int          LEN_W       = 24,
  parameter int unsigned TEST_LEN    = 32'h0040_0000,
  parameter int          RD_LATENCY  = 1,
  parameter int unsigned GAP_CYCLES  = 1024,
  parameter int unsigned LOAD_CYCLES = 4,
  parameter int unsigned MAX_PASSES  = 0
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             sdram_init_done,
  input  logic [1:0]       mode,
  input  logic             stop_on_err,
  input  logic             wr_ready,
  input  logic             rd_ready,
  output logic             wr_en,
  output logic [DW-1:0]    wr_data,
  output logic             rd_en,
  input  logic [DW-1:0]    rd_data,
  output logic             port_load,
  output logic             error_flag,
  output logic [15:0]      err_cnt,
  output logic [3:0]       pass_cnt,
  output logic             busy
`ifdef SDRAM_TEST_ERR_LOG_EN
  ,
  output logic [LEN_W-1:0] first_err_addr,
  output logic [DW-1:0]    first_exp,
  output logic [DW-1:0]    first_act
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_GAP, S_READ, S_DRAIN, S_STOP} state_t;

  localparam logic [15:0]      SEED       = 16'hACE1;
  localparam logic [LEN_W-1:0] LAST_IDX   = LEN_W'(TEST_LEN - 1);
  localparam logic [31:0]      LOAD_LAST  = (LOAD_CYCLES > 0) ? 32'(LOAD_CYCLES - 1) : 32'd0;
  localparam logic [31:0]      GAP_LAST   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  // rd_en is registered, so the last compare lands RD_LATENCY cycles after the
  // first DRAIN cycle: DRAIN lasts RD_LATENCY+1 cycles.
  localparam logic [31:0]      DRAIN_LAST = 32'(RD_LATENCY);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       done_q, done_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              error_flag_q, error_flag_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              port_load_q, port_load_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [DW-1:0]     rd_exp_q, rd_exp_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [DW-1:0]     pipe_exp_q [RD_LATENCY];
  logic [DW-1:0]     pipe_exp_d [RD_LATENCY];
`ifdef SDRAM_TEST_ERR_LOG_EN
  logic [LEN_W-1:0]  rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  pipe_addr_q [RD_LATENCY];
  logic [LEN_W-1:0]  pipe_addr_d [RD_LATENCY];
  logic [LEN_W-1:0]  first_err_addr_q, first_err_addr_d;
  logic [DW-1:0]     first_exp_q, first_exp_d;
  logic [DW-1:0]     first_act_q, first_act_d;
`endif

  logic [15:0]   lfsr_nxt;
  logic [DW-1:0] word;
  logic          mismatch;
  logic          abort;
  logic          start_pass;

  // The word for index i uses the LFSR value after it has been shifted for i.
  function automatic logic [DW-1:0] gen_pattern(input logic [1:0] m, input logic [LEN_W-1:0] i,
                                                input logic [15:0] l);
    logic [DW+LEN_W-1:0] ext;
    logic [DW-1:0]       inc;
    logic [DW-1:0]       walk;
    logic [DW-1:0]       lf;
    logic [LEN_W-1:0]    sh;
    ext  = {{DW{1'b0}}, i};
    inc  = ext[DW-1:0];
    sh   = i % LEN_W'(DW);
    walk = DW'(1) << sh;
    for (int b = 0; b < DW; b++) lf[b] = l[b % 16];
    case (m)
      2'd0:    return inc;
      2'd1:    return walk;
      2'd2:    return lf;
      default: return ~inc;
    endcase
  endfunction

  assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign word     = gen_pattern(mode_q, idx_q, lfsr_nxt) ^ {DW{pass_cnt_q[0]}};
  assign mismatch = pipe_vld_q[RD_LATENCY-1] && (pipe_exp_q[RD_LATENCY-1] != rd_data);
  assign abort    = !sdram_init_done && (state_q != S_IDLE) && (state_q != S_STOP);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    error_flag_d = error_flag_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    port_load_d  = 1'b0;
    wr_data_d    = wr_data_q;
    rd_exp_d     = rd_exp_q;
    start_pass   = 1'b0;
    // Expected-data pipe tracks issued reads until their data returns.
    pipe_vld_d[0] = rd_en_q;
    pipe_exp_d[0] = rd_exp_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_exp_d[k] = pipe_exp_q[k-1];
    end
`ifdef SDRAM_TEST_ERR_LOG_EN
    rd_addr_d        = rd_addr_q;
    first_err_addr_d = first_err_addr_q;
    first_exp_d      = first_exp_q;
    first_act_d      = first_act_q;
    pipe_addr_d[0]   = rd_addr_q;
    for (int k = 1; k < RD_LATENCY; k++) pipe_addr_d[k] = pipe_addr_q[k-1];
    if (mismatch && !abort && !error_flag_q) begin
      first_err_addr_d = pipe_addr_q[RD_LATENCY-1];
      first_exp_d      = pipe_exp_q[RD_LATENCY-1];
      first_act_d      = rd_data;
    end
`endif

    if (mismatch && !abort) begin
      error_flag_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: if (sdram_init_done) start_pass = 1'b1;
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_WRITE;
        end else begin
          cnt_d       = cnt_q + 32'd1;
          port_load_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          wr_en_d   = 1'b1;
          wr_data_d = word;
          idx_d     = idx_q + 1'b1;
          lfsr_d    = lfsr_nxt;
          if (idx_q == LAST_IDX) begin
            state_d = S_GAP;
            cnt_d   = 32'd0;
          end
        end
      end
      S_GAP: begin
        idx_d  = '0;
        lfsr_d = SEED;
        if (cnt_q == GAP_LAST) state_d = S_READ;
        else                   cnt_d   = cnt_q + 32'd1;
      end
      S_READ: begin
        if (rd_ready) begin
          rd_en_d  = 1'b1;
          rd_exp_d = word;
`ifdef SDRAM_TEST_ERR_LOG_EN
          rd_addr_d = idx_q;
`endif
          idx_d    = idx_q + 1'b1;
          lfsr_d   = lfsr_nxt;
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
            cnt_d   = 32'd0;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          pass_cnt_d = pass_cnt_q + 4'd1;
          done_d     = done_q + 32'd1;
          if ((MAX_PASSES != 0) && (done_d == 32'(MAX_PASSES))) state_d = S_STOP;
          else                                                  start_pass = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase

    if (start_pass) begin
      state_d     = S_LOAD;
      port_load_d = 1'b1;
      cnt_d       = 32'd0;
      idx_d       = '0;
      mode_d      = mode;
      lfsr_d      = SEED;
    end

    // Controller loss and stop-on-error both abandon the pass without counting it.
    if (abort || (mismatch && stop_on_err)) begin
      state_d     = abort ? S_IDLE : S_STOP;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      port_load_d = 1'b0;
      pass_cnt_d  = pass_cnt_q;
      done_d      = done_q;
    end

    if ((state_d == S_IDLE) || (state_d == S_STOP)) pipe_vld_d = '0;
    busy_d = (state_d != S_IDLE) && (state_d != S_STOP);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lfsr_q       <= SEED;
      mode_q       <= 2'd0;
      cnt_q        <= 32'd0;
      done_q       <= 32'd0;
      pass_cnt_q   <= 4'd0;
      err_cnt_q    <= 16'd0;
      error_flag_q <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      port_load_q  <= 1'b0;
      busy_q       <= 1'b0;
      wr_data_q    <= '0;
      rd_exp_q     <= '0;
      pipe_vld_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_exp_q[k] <= '0;
`ifdef SDRAM_TEST_ERR_LOG_EN
      rd_addr_q        <= '0;
      first_err_addr_q <= '0;
      first_exp_q      <= '0;
      first_act_q      <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_addr_q[k] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      error_flag_q <= error_flag_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      port_load_q  <= port_load_d;
      busy_q       <= busy_d;
      wr_data_q    <= wr_data_d;
      rd_exp_q     <= rd_exp_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_exp_q   <= pipe_exp_d;
`ifdef SDRAM_TEST_ERR_LOG_EN
      rd_addr_q        <= rd_addr_d;
      pipe_addr_q      <= pipe_addr_d;
      first_err_addr_q <= first_err_addr_d;
      first_exp_q      <= first_exp_d;
      first_act_q      <= first_act_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign rd_en      = rd_en_q;
  assign port_load  = port_load_q;
  assign error_flag = error_flag_q;
  assign err_cnt    = err_cnt_q;
  assign pass_cnt   = pass_cnt_q;
  assign busy       = busy_q;
`ifdef SDRAM_TEST_ERR_LOG_EN
  assign first_err_addr = first_err_addr_q;
  assign first_exp      = first_exp_q;
  assign first_act      = first_act_q;
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester with a small behavioural FIFO/SDRAM model.
// Expected write words are queued when a run is launched and checked against the
// words the DUT actually strobed out.
module tb_sdram_pattern_tester;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        initDone = 1'b0;
   logic [1:0]  modeSel = 2'd0;
   logic        stopOnErr = 1'b0;
   logic        toggleEn = 1'b0;
   logic        togQ = 1'b0;
   logic        wrReady;
   logic        rdReady;
   logic        wrEn;
   logic [15:0] wrData;
   logic        rdEn;
   logic [15:0] rdData;
   logic        portLoad;
   logic        errorFlag;
   logic [15:0] errCnt;
   logic [3:0]  passCnt;
   logic        busy;
`ifdef SDRAM_TEST_ERR_LOG_EN
   logic [23:0] firstErrAddr;
   logic [15:0] firstExp;
   logic [15:0] firstAct;
`endif

   int          nChecks = 0;
   int          nFails = 0;
   int          corruptAddr = -1;
   logic [15:0] expWr[$];

   // Monitor-owned observation state, cleared by reset.
   logic [15:0] obsWr [64];
   int          obsWrN;
   int          obsRdN;
   int          bothN;
   int          plRun;
   int          plLast;

   logic [15:0] mem [8];
   int          wAddr;
   int          rAddr;

   assign wrReady = toggleEn ? togQ : 1'b1;
   assign rdReady = toggleEn ? ~togQ : 1'b1;

   always #5 clk = ~clk;

   sdram_pattern_tester #(
      .DW(16), .LEN_W(24), .TEST_LEN(8), .RD_LATENCY(1),
      .GAP_CYCLES(4), .LOAD_CYCLES(4), .MAX_PASSES(2)
   ) dut (
      .clk_50m(clk), .rst_n(rstN), .sdram_init_done(initDone), .mode(modeSel),
      .stop_on_err(stopOnErr), .wr_ready(wrReady), .rd_ready(rdReady),
      .wr_en(wrEn), .wr_data(wrData), .rd_en(rdEn), .rd_data(rdData),
      .port_load(portLoad), .error_flag(errorFlag), .err_cnt(errCnt),
      .pass_cnt(passCnt), .busy(busy)
`ifdef SDRAM_TEST_ERR_LOG_EN
      , .first_err_addr(firstErrAddr), .first_exp(firstExp), .first_act(firstAct)
`endif
   );

   // Memory model: port_load rewinds both address pointers, one-cycle read latency,
   // optional single-word corruption of bit 0 on write.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wAddr  <= 0;
         rAddr  <= 0;
         rdData <= 16'h0;
      end else begin
         if (portLoad) begin
            wAddr <= 0;
            rAddr <= 0;
         end
         if (wrEn) begin
            mem[wAddr % 8] <= wrData ^ ((wAddr == corruptAddr) ? 16'h0001 : 16'h0000);
            wAddr <= wAddr + 1;
         end
         if (rdEn) begin
            rdData <= mem[rAddr % 8];
            rAddr  <= rAddr + 1;
         end
      end
   end

   // Observation monitor sampling on the falling edge, away from the active edge.
   always @(negedge clk) begin
      togQ <= ~togQ;
      if (!rstN) begin
         obsWrN <= 0;
         obsRdN <= 0;
         bothN  <= 0;
         plRun  <= 0;
         plLast <= 0;
      end else begin
         if (wrEn) begin
            if (obsWrN < 64) obsWr[obsWrN] <= wrData;
            obsWrN <= obsWrN + 1;
         end
         if (rdEn) obsRdN <= obsRdN + 1;
         if (wrEn && rdEn) bothN <= bothN + 1;
         if (portLoad) plRun <= plRun + 1;
         else if (plRun != 0) begin
            plLast <= plRun;
            plRun  <= 0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] lfsrStep(input logic [15:0] x);
      return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
   endfunction

   // Queue the eight words one pass should write.
   task automatic pushPass(input logic [1:0] m, input logic inv);
      logic [15:0] l;
      logic [15:0] w;
      l = 16'hACE1;
      for (int i = 0; i < 8; i++) begin
         l = lfsrStep(l);
         case (m)
            2'd0:    w = 16'(i);
            2'd1:    w = 16'h0001 << i;
            2'd2:    w = l;
            default: w = ~16'(i);
         endcase
         expWr.push_back(inv ? ~w : w);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input int corrupt, input logic stopErr,
                                input logic tog);
      rstN        = 1'b0;
      initDone    = 1'b0;
      modeSel     = m;
      corruptAddr = corrupt;
      stopOnErr   = stopErr;
      toggleEn    = tog;
      expWr.delete();
      repeat (3) tick();
      rstN = 1'b1;
      tick();
      initDone = 1'b1;
   endtask

   task automatic waitForStop(input string tag);
      logic seen;
      logic done;
      seen = 1'b0;
      done = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         tick();
         if (busy) seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      checkOutput({tag, "_finished"}, {31'd0, done}, 32'd1);
   endtask

   task automatic compareWrites(input string tag);
      int n;
      n = expWr.size();
      checkOutput({tag, "_wr_count"}, obsWrN, n);
      for (int i = 0; i < obsWrN && i < 64 && expWr.size() != 0; i++)
         checkOutput($sformatf("%s_wr_data[%0d]", tag, i), obsWr[i], expWr.pop_front());
      checkOutput({tag, "_wr_rd_overlap"}, bothN, 0);
   endtask

   initial begin
      $display("[TB] reset state");
      repeat (3) tick();
      checkOutput("rst_wr_en", wrEn, 0);
      checkOutput("rst_rd_en", rdEn, 0);
      checkOutput("rst_wr_data", wrData, 0);
      checkOutput("rst_port_load", portLoad, 0);
      checkOutput("rst_error_flag", errorFlag, 0);
      checkOutput("rst_err_cnt", errCnt, 0);
      checkOutput("rst_pass_cnt", passCnt, 0);
      checkOutput("rst_busy", busy, 0);
      // Still idle with reset released but no controller ready.
      rstN = 1'b1;
      repeat (5) tick();
      checkOutput("idle_busy", busy, 0);

      $display("[TB] INC, clean memory");
      applyStimulus(2'd0, -1, 1'b0, 1'b0);
      pushPass(2'd0, 1'b0);
      pushPass(2'd0, 1'b1);
      waitForStop("inc");
      compareWrites("inc");
      checkOutput("inc_rd_count", obsRdN, 16);
      checkOutput("inc_error_flag", errorFlag, 0);
      checkOutput("inc_err_cnt", errCnt, 0);
      checkOutput("inc_pass_cnt", passCnt, 2);
      checkOutput("inc_port_load_len", plLast, 4);

      $display("[TB] INC, word 5 bit 0 corrupted");
      applyStimulus(2'd0, 5, 1'b0, 1'b0);
      pushPass(2'd0, 1'b0);
      pushPass(2'd0, 1'b1);
      waitForStop("corrupt");
      compareWrites("corrupt");
      checkOutput("corrupt_error_flag", errorFlag, 1);
      checkOutput("corrupt_err_cnt", errCnt, 2);
      checkOutput("corrupt_pass_cnt", passCnt, 2);
`ifdef SDRAM_TEST_ERR_LOG_EN
      checkOutput("corrupt_first_addr", firstErrAddr, 5);
      checkOutput("corrupt_first_exp", firstExp, 16'h0005);
      checkOutput("corrupt_first_act", firstAct, 16'h0004);
`endif

      $display("[TB] WALK1");
      applyStimulus(2'd1, -1, 1'b0, 1'b0);
      pushPass(2'd1, 1'b0);
      pushPass(2'd1, 1'b1);
      waitForStop("walk");
      checkOutput("walk_first_word", obsWr[0], 16'h0001);
      checkOutput("walk_last_word", obsWr[7], 16'h0080);
      compareWrites("walk");
      checkOutput("walk_err_cnt", errCnt, 0);

      $display("[TB] LFSR");
      applyStimulus(2'd2, -1, 1'b0, 1'b0);
      pushPass(2'd2, 1'b0);
      pushPass(2'd2, 1'b1);
      waitForStop("lfsr");
      checkOutput("lfsr_first_word", obsWr[0], 16'h5670);
      compareWrites("lfsr");
      checkOutput("lfsr_err_cnt", errCnt, 0);

      $display("[TB] NOT-INC with toggling ready");
      applyStimulus(2'd3, -1, 1'b0, 1'b1);
      pushPass(2'd3, 1'b0);
      pushPass(2'd3, 1'b1);
      waitForStop("tog");
      compareWrites("tog");
      checkOutput("tog_rd_count", obsRdN, 16);
      checkOutput("tog_err_cnt", errCnt, 0);
      checkOutput("tog_pass_cnt", passCnt, 2);
      toggleEn = 1'b0;

      $display("[TB] init_done dropped during READ");
      begin
         logic seenRd;
         applyStimulus(2'd0, -1, 1'b0, 1'b0);
         pushPass(2'd0, 1'b0);
         pushPass(2'd0, 1'b0);
         pushPass(2'd0, 1'b1);
         seenRd = 1'b0;
         for (int n = 0; n < 500 && !seenRd; n++) begin
            tick();
            if (rdEn) seenRd = 1'b1;
         end
         checkOutput("drop_reached_read", {31'd0, seenRd}, 32'd1);
         initDone = 1'b0;
         tick();
         tick();
         checkOutput("drop_busy", busy, 0);
         checkOutput("drop_rd_en", rdEn, 0);
         checkOutput("drop_err_cnt", errCnt, 0);
         checkOutput("drop_pass_cnt", passCnt, 0);
         repeat (5) tick();
         initDone = 1'b1;
         waitForStop("drop");
         compareWrites("drop");
         checkOutput("drop_final_pass_cnt", passCnt, 2);
         checkOutput("drop_final_err_cnt", errCnt, 0);
         checkOutput("drop_port_load_len", plLast, 4);
      end

      $display("[TB] stop_on_err with error at word 2");
      applyStimulus(2'd0, 2, 1'b1, 1'b0);
      pushPass(2'd0, 1'b0);
      waitForStop("stop");
      compareWrites("stop");
      checkOutput("stop_err_cnt", errCnt, 1);
      checkOutput("stop_error_flag", errorFlag, 1);
      checkOutput("stop_busy", busy, 0);
      checkOutput("stop_pass_cnt", passCnt, 0);
      checkOutput("stop_rd_count", obsRdN, 4);
      repeat (20) tick();
      checkOutput("stop_rd_count_hold", obsRdN, 4);
      checkOutput("stop_err_cnt_hold", errCnt, 1);

      $display("[TB] reset asserted mid-write");
      begin
         logic seenWr;
         applyStimulus(2'd0, -1, 1'b0, 1'b0);
         seenWr = 1'b0;
         for (int n = 0; n < 200 && !seenWr; n++) begin
            tick();
            if (wrEn) seenWr = 1'b1;
         end
         checkOutput("midrst_reached_write", {31'd0, seenWr}, 32'd1);
         rstN = 1'b0;
         #1;
         checkOutput("midrst_wr_en", wrEn, 0);
         checkOutput("midrst_wr_data", wrData, 0);
         checkOutput("midrst_busy", busy, 0);
         checkOutput("midrst_pass_cnt", passCnt, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
